// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   word_t       32-bit bus word used for addresses and data
//   ramstate_t   status reported by the RAM model each cycle
//   arb_state_t  arbiter FSM state
//   ARB_STARVE_W width of the starvation counter (STARVE_MAX up to 15)
//   ARB_TO_W     width of the grant timeout counter (TIMEOUT up to 255)
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    localparam int ARB_STARVE_W = 4;
    localparam int ARB_TO_W     = 8;

endpackage

// File: rtl/arbiter_if.sv
// Bundle of every arbiter-facing signal except clock and reset.
//   modport arb : the arbiter's view (requests and RAM status in, stalls and strobes out)
//   modport tb  : the opposite view, for pipeline/RAM models driving the arbiter
interface arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Sequential arbiter sharing one single-ported RAM between instruction
// fetch (I) and data access (D). D wins by default; after STARVE_MAX
// consecutive D grants taken while I was waiting, I is forced through.
// A grant the RAM never completes is aborted after TIMEOUT cycles and
// raises the sticky memerr flag.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request / address
//   iload, iwait         instruction data (= ramload) / fetch stall
//   dREN, dWEN           data read / write request (write wins if both)
//   daddr, dstore        data address / write data
//   dload, dwait         data read value (= ramload) / data stall
//   ramREN, ramWEN       RAM strobes, valid only while a grant is held
//   ramaddr, ramstore    RAM address / write data (0 when idle)
//   ramload, ramstate    RAM read data / RAM status
//   memerr               sticky timeout-or-RAM-error flag, cleared by nRST
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(STARVE_MAX);
    localparam logic [ARB_TO_W-1:0]     TO_LAST    = ARB_TO_W'(TIMEOUT - 1);

    arb_state_t               state, state_n;
    logic [ARB_STARVE_W-1:0]  starve_cnt, starve_n;
    logic [ARB_TO_W-1:0]      to_cnt, to_n;
    logic                     err_set;
    logic                     d_pend;
    logic                     grant_req;

    // Saturating increment for the starvation counter.
    function automatic logic [ARB_STARVE_W-1:0] sat_inc(input logic [ARB_STARVE_W-1:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 1'b1;
    endfunction

    assign d_pend = dREN | dWEN;

    // The currently granted requester's request line; used to detect withdrawal.
    assign grant_req = (state == ARB_I) ? iREN : d_pend;

    // Next-state, counter and error decisions
    always_comb begin
        state_n  = state;
        starve_n = starve_cnt;
        to_n     = '0;
        err_set  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_pend && !(iREN && starve_cnt == STARVE_LIM)) begin
                    state_n = ARB_D;
                    if (iREN) starve_n = sat_inc(starve_cnt);
                end else if (iREN) begin
                    state_n  = ARB_I;
                    starve_n = '0;
                end
            end
            ARB_I, ARB_D: begin
                // Every exit goes back through IDLE so a request the pipeline
                // retires on this edge is never served a second time.
                if (ramstate == ACCESS) begin
                    state_n = ARB_IDLE;
                end else if (ramstate == ERROR) begin
                    state_n = ARB_IDLE;
                    err_set = 1'b1;
                end else if (!grant_req) begin
                    state_n = ARB_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    state_n = ARB_IDLE;
                    err_set = 1'b1;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            memerr     <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            to_cnt     <= to_n;
            if (err_set) memerr <= 1'b1;
        end
    end

    // RAM side follows the registered grant and the granted requester's
    // live inputs, so a withdrawn request drops its strobe in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            ARB_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            ARB_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN   & ~(state == ARB_I && ramstate == ACCESS);
    assign dwait = d_pend & ~(state == ARB_D && ramstate == ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (STARVE_MAX=4, TIMEOUT=15).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iload    (bus.iload),
        .iwait    (bus.iwait),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dload    (bus.dload),
        .dwait    (bus.dwait),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .memerr   (bus.memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        #2;
        step();
        step();
        checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, ARB_IDLE); end
        checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL reset_strobes: got REN=%b WEN=%b want 0/0", bus.ramREN, bus.ramWEN); end
        checks++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram_bus: got addr=%h store=%h want 0/0", bus.ramaddr, bus.ramstore); end
        checks++; if (bus.memerr !== 1'b0) begin errors++; $display("FAIL reset_memerr: got %b want 0", bus.memerr); end
        checks++; if (dut.starve_cnt !== 4'd0 || dut.to_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got starve=%0d to=%0d want 0/0", dut.starve_cnt, dut.to_cnt); end
        // Stalls are combinational and follow requests even while held in reset.
        bus.iREN = 1'b1;
        bus.dWEN = 1'b1;
        #1;
        checks++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin errors++; $display("FAIL reset_waits: got iwait=%b dwait=%b want 1/1", bus.iwait, bus.dwait); end
        step();
        checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL reset_hold_strobes: got REN=%b WEN=%b want 0/0", bus.ramREN, bus.ramWEN); end
        clear_inputs();
        #1;
        checks++; if (bus.iwait !== 1'b0 || bus.dwait !== 1'b0) begin errors++; $display("FAIL reset_waits_idle: got iwait=%b dwait=%b want 0/0", bus.iwait, bus.dwait); end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_i_fetch();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1234_5678;
        #1;
        checks++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL ifetch_c0: got iwait=%b ramREN=%b want 1/0", bus.iwait, bus.ramREN); end
        step();
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_c1_ram: got REN=%b addr=%h want 1/00000040", bus.ramREN, bus.ramaddr); end
        checks++; if (bus.iwait !== 1'b0) begin errors++; $display("FAIL ifetch_c1_iwait: got %b want 0", bus.iwait); end
        checks++; if (bus.iload !== 32'h1234_5678) begin errors++; $display("FAIL ifetch_iload: got %h want 12345678", bus.iload); end
        bus.iREN = 1'b0;
        step();
        checks++; if (dut.state !== ARB_IDLE || bus.ramREN !== 1'b0) begin errors++; $display("FAIL ifetch_c2_idle: got state=%0d REN=%b want 0/0", dut.state, bus.ramREN); end
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic [31:0] want_addr [5];
        want_addr[0] = 32'h200; want_addr[1] = 32'h200; want_addr[2] = 32'h200;
        want_addr[3] = 32'h200; want_addr[4] = 32'h10;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h10;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h200;
        bus.ramstate = ACCESS;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) begin
                checks++; if (dut.starve_cnt !== 4'd4) begin errors++; $display("FAIL starve_sat: got %0d want 4", dut.starve_cnt); end
            end
            step();
            checks++; if (bus.ramaddr !== want_addr[g] || bus.ramREN !== 1'b1) begin errors++; $display("FAIL starve_grant%0d: got addr=%h REN=%b want %h/1", g, bus.ramaddr, bus.ramREN, want_addr[g]); end
            if (g == 4) begin
                bus.iREN = 1'b0;
                bus.dREN = 1'b0;
            end
            step();
        end
        checks++; if (dut.starve_cnt !== 4'd0 || dut.state !== ARB_IDLE) begin errors++; $display("FAIL starve_clear: got cnt=%0d state=%0d want 0/0", dut.starve_cnt, dut.state); end
        clear_inputs();
    endtask

    task automatic test_d_write();
        bus.dWEN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'hDEAD_BEEF;
        bus.ramstate = BUSY;
        bus.ramload  = 32'hCAFE_0001;
        #1;
        checks++; if (bus.dwait !== 1'b1) begin errors++; $display("FAIL dwr_c0_dwait: got %b want 1", bus.dwait); end
        step();
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL dwr_strobes: got WEN=%b REN=%b want 1/0", bus.ramWEN, bus.ramREN); end
        checks++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dwr_bus: got addr=%h store=%h want 00000100/deadbeef", bus.ramaddr, bus.ramstore); end
        checks++; if (bus.dwait !== 1'b1) begin errors++; $display("FAIL dwr_busy_dwait: got %b want 1", bus.dwait); end
        bus.ramstate = ACCESS;
        #1;
        checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'hCAFE_0001) begin errors++; $display("FAIL dwr_access: got dwait=%b dload=%h want 0/cafe0001", bus.dwait, bus.dload); end
        step();
        bus.dWEN = 1'b0;
        bus.dREN = 1'b0;
        #1;
        checks++; if (dut.state !== ARB_IDLE || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0) begin errors++; $display("FAIL dwr_idle: got state=%0d WEN=%b addr=%h want 0/0/0", dut.state, bus.ramWEN, bus.ramaddr); end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h80;
        bus.ramstate = BUSY;
        step();
        checks++; if (bus.ramREN !== 1'b1 || bus.iwait !== 1'b1) begin errors++; $display("FAIL wd_c1: got REN=%b iwait=%b want 1/1", bus.ramREN, bus.iwait); end
        step();
        bus.iREN = 1'b0;
        #1;
        checks++; if (bus.ramREN !== 1'b0 || dut.state !== ARB_I) begin errors++; $display("FAIL wd_c2: got REN=%b state=%0d want 0/1", bus.ramREN, dut.state); end
        step();
        checks++; if (dut.state !== ARB_IDLE || bus.memerr !== 1'b0) begin errors++; $display("FAIL wd_c3: got state=%0d memerr=%b want 0/0", dut.state, bus.memerr); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.ramstate = BUSY;
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (dut.state !== ARB_D || bus.dwait !== 1'b1 || bus.memerr !== 1'b0) begin errors++; $display("FAIL to_grant%0d: got state=%0d dwait=%b memerr=%b want 2/1/0", k, dut.state, bus.dwait, bus.memerr); end
        end
        step();
        checks++; if (dut.state !== ARB_IDLE || bus.memerr !== 1'b1 || bus.dwait !== 1'b1) begin errors++; $display("FAIL to_abort: got state=%0d memerr=%b dwait=%b want 0/1/1", dut.state, bus.memerr, bus.dwait); end
        step();
        checks++; if (dut.state !== ARB_D || dut.to_cnt !== 8'd0 || bus.memerr !== 1'b1) begin errors++; $display("FAIL to_regrant: got state=%0d to=%0d memerr=%b want 2/0/1", dut.state, dut.to_cnt, bus.memerr); end
        bus.dREN = 1'b0;
        step();
        checks++; if (dut.state !== ARB_IDLE || bus.memerr !== 1'b1) begin errors++; $display("FAIL to_sticky: got state=%0d memerr=%b want 0/1", dut.state, bus.memerr); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_grant();
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.ramstate = BUSY;
        step();
        step();
        checks++; if (dut.state !== ARB_D || bus.ramREN !== 1'b1 || dut.starve_cnt !== 4'd1) begin errors++; $display("FAIL rmg_pre: got state=%0d REN=%b starve=%0d want 2/1/1", dut.state, bus.ramREN, dut.starve_cnt); end
        nRST = 1'b0;
        #1;
        checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL rmg_strobes: got REN=%b WEN=%b want 0/0", bus.ramREN, bus.ramWEN); end
        checks++; if (dut.state !== ARB_IDLE || dut.starve_cnt !== 4'd0 || dut.to_cnt !== 8'd0) begin errors++; $display("FAIL rmg_state: got state=%0d starve=%0d to=%0d want 0/0/0", dut.state, dut.starve_cnt, dut.to_cnt); end
        checks++; if (bus.memerr !== 1'b0 || bus.dwait !== 1'b1) begin errors++; $display("FAIL rmg_memerr: got memerr=%b dwait=%b want 0/1", bus.memerr, bus.dwait); end
        clear_inputs();
        #2;
        nRST = 1'b1;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST   = 1'b0;
        test_reset();
        test_i_fetch();
        test_starvation();
        test_d_write();
        test_withdraw();
        test_timeout();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
